// File: rtl/mig_read_streamer.sv
// Streams a block of DDR reads from a MIG user interface into a small FIFO and
// out to a ready/valid consumer, with credit-based flow control so the FIFO never overflows.
module mig_read_streamer #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int ADDR_INC   = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_beats,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       issue_left;
    logic [15:0]       out_left;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_cnt;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              done_q;
    logic              err_q;
    logic [CW:0]       credit_sum;
    logic              credit;
    logic              accept, issue, push, pop, last_pop;

    // Every beat in flight or buffered already owns a FIFO slot.
    assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_cnt};
    assign credit     = credit_sum < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        app_en    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = rst_n && init_calib_complete;
                if (cmd_valid && cmd_ready && cmd_beats != 16'd0)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                app_en = (issue_left != 16'd0) && credit;
                if (app_en && app_rdy && issue_left == 16'd1)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = cmd_valid && cmd_ready;
    assign issue     = app_en && app_rdy;
    assign push      = app_rd_data_valid && (outstanding != '0);
    assign pop       = out_valid && out_ready;
    assign last_pop  = pop && out_last;

    assign app_cmd   = 3'b001;
    assign app_addr  = addr_q;
    assign out_valid = fifo_cnt != '0;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign out_last  = out_valid && (out_left == 16'd1);
    assign busy      = state != IDLE;
    assign done      = done_q;
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            issue_left  <= '0;
            out_left    <= '0;
            outstanding <= '0;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= cmd_addr;
                issue_left <= cmd_beats;
                out_left   <= cmd_beats;
            end else begin
                if (issue) begin
                    addr_q     <= addr_q + ADDR_W'(ADDR_INC);
                    issue_left <= issue_left - 16'd1;
                end
                if (pop)
                    out_left <= out_left - 16'd1;
            end
            case ({issue, push})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            // A return with nothing outstanding is dropped and flagged until reset.
            if (app_rd_data_valid && outstanding == '0)
                err_q <= 1'b1;
            done_q <= (accept && cmd_beats == 16'd0) || last_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= app_rd_data;
    end
endmodule

// File: tb/tb_mig_read_streamer.sv
// Bench for mig_read_streamer: MIG read model plus a queue-based reference of the
// expected address and data streams, checked every cycle at the falling edge.
module tb_mig_read_streamer;
    localparam int ADDR_W     = 28;
    localparam int DATA_W     = 128;
    localparam int ADDR_INC   = 8;
    localparam int FIFO_DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              init_calib_complete = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [15:0]       cmd_beats = '0;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_rdy = 1'b0;
    logic [DATA_W-1:0] app_rd_data = '0;
    logic              app_rd_data_valid = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mig_read_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_INC(ADDR_INC),
                        .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_beats(cmd_beats), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_rdy(app_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return {~w, w * 32'd3, w ^ 32'h5a5a_5a5a, w};
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Stimulus knobs (main process) and the MIG/consumer driver state.
    int          lat = 3;
    int          rdy_mode = 0;
    int          ord_mode = 1;
    int          stray_req = 0;
    int          stray_done = 0;
    int          pat_idx = 0;
    logic [3:0]  rdy_pat = 4'b1001;
    longint      cyc = 0;
    logic              ret_v = 1'b0;
    logic [DATA_W-1:0] ret_d = '0;

    always @(posedge clk) begin
        cyc++;
        #1;
        case (rdy_mode)
            0:       app_rdy = 1'b1;
            1:       app_rdy = 1'($urandom_range(0, 1));
            default: begin app_rdy = rdy_pat[pat_idx % 4]; pat_idx++; end
        endcase
        case (ord_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (stray_done < stray_req) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = beat_data(28'h0DEAD00);
            stray_done++;
        end else begin
            app_rd_data_valid = ret_v;
            app_rd_data = ret_d;
        end
    end

    // Reference model: what must be issued, returned and delivered.
    typedef struct { logic [ADDR_W-1:0] a; longint due; } rd_t;
    rd_t               mig_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W:0]   exp_out_q[$];
    logic [ADDR_W-1:0] iss_log[$];
    int  mout = 0, inflight = 0, n_out = 0, n_done = 0;
    bit  merr = 0, mbusy = 0, exp_done = 0, nd = 0;
    bit  st_app = 0, st_out = 0;
    logic [ADDR_W-1:0] hold_addr = '0, a_tmp = '0;
    logic [DATA_W:0]   hold_out = '0, e_tmp = '0;

    always @(negedge clk) begin
        chk("app_cmd", app_cmd, 3'b001);
        if (!rst_n) begin
            chk("rst_flags", {cmd_ready, app_en, out_valid, out_last, busy, done, err}, 0);
            chk("rst_app_addr", app_addr, 0);
            chk("rst_out_data", out_data, 0);
            mig_q.delete(); exp_addr_q.delete(); exp_out_q.delete();
            mout = 0; inflight = 0; merr = 0; mbusy = 0; exp_done = 0;
            st_app = 0; st_out = 0; ret_v = 1'b0;
        end else begin
            nd = 0;
            chk("cmd_ready", cmd_ready, !mbusy && init_calib_complete);
            chk("busy", busy, mbusy);
            chk("done", done, exp_done);
            chk("err", err, merr);
            if (st_app) begin
                chk("app_en_hold", app_en, 1);
                chk("app_addr_hold", app_addr, hold_addr);
            end
            if (st_out) begin
                chk("out_valid_hold", out_valid, 1);
                chk("out_hold", {out_last, out_data}, hold_out);
            end
            st_app = app_en && !app_rdy;  hold_addr = app_addr;
            st_out = out_valid && !out_ready; hold_out = {out_last, out_data};
            if (app_rd_data_valid) begin
                if (mout == 0) merr = 1;
                else mout--;
            end
            if (app_en && app_rdy) begin
                chk("credit", inflight < FIFO_DEPTH, 1);
                if (exp_addr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_issue actual=%0h expected=none", app_addr);
                end else begin
                    chk("app_addr", app_addr, exp_addr_q.pop_front());
                end
                mig_q.push_back('{app_addr, cyc + longint'(lat)});
                iss_log.push_back(app_addr);
                mout++; inflight++;
            end
            if (out_valid && out_ready) begin
                if (exp_out_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat actual=%0h expected=none", out_data);
                end else begin
                    e_tmp = exp_out_q.pop_front();
                    chk("out_data", out_data, e_tmp[DATA_W-1:0]);
                    chk("out_last", out_last, e_tmp[DATA_W]);
                    if (e_tmp[DATA_W]) begin nd = 1; mbusy = 0; end
                end
                inflight--; n_out++;
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_beats == 16'd0) nd = 1;
                else mbusy = 1;
                for (int k = 0; k < int'(cmd_beats); k++) begin
                    a_tmp = cmd_addr + ADDR_W'(k * ADDR_INC);
                    exp_addr_q.push_back(a_tmp);
                    exp_out_q.push_back({k == int'(cmd_beats) - 1, beat_data(a_tmp)});
                end
            end
            if (done) n_done++;
            exp_done = nd;
            ret_v = 1'b0;
            if (mig_q.size() > 0 && mig_q[0].due <= cyc + 1) begin
                ret_v = 1'b1;
                ret_d = beat_data(mig_q[0].a);
                void'(mig_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [15:0] n);
        int t;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_beats = n; t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ready && t < 1000);
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL cmd_accept_timeout actual=0 expected=1");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (n_done <= d0 && t < 5000) begin @(negedge clk); t++; end
        chk("done_seen", n_done > d0, 1);
        @(negedge clk);
    endtask

    logic [ADDR_W-1:0] e046 [4] = '{28'h100, 28'h108, 28'h110, 28'h118};
    int base, o0, d0, t;

    initial begin
        init_calib_complete = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready_calib", cmd_ready, 0);
        chk("rst_app_cmd", app_cmd, 3'b001);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);

        // Basic 4-beat read
        base = iss_log.size(); o0 = n_out; d0 = n_done;
        send_cmd(28'h100, 16'd4);
        wait_done(d0);
        chk("t046_issued", iss_log.size() - base, 4);
        for (int k = 0; k < 4; k++) chk("t046_addr", iss_log[base + k], e046[k]);
        chk("t046_beats", n_out - o0, 4);
        chk("t046_done", n_done - d0, 1);

        // Credit limit with a stalled consumer; calibration dropping mid-transfer is ignored
        ord_mode = 0;
        base = iss_log.size(); o0 = n_out; d0 = n_done;
        send_cmd(28'h2000, 16'd40);
        init_calib_complete = 1'b0;
        repeat (200) @(negedge clk);
        chk("t047_issued_stall", iss_log.size() - base, 16);
        chk("t047_app_en_stall", app_en, 0);
        ord_mode = 1;
        wait_done(d0);
        init_calib_complete = 1'b1;
        chk("t047_issued", iss_log.size() - base, 40);
        chk("t047_beats", n_out - o0, 40);
        chk("t047_err", err, 0);

        // app_rdy 1-0-0-1 pattern
        rdy_mode = 2;
        base = iss_log.size(); d0 = n_done;
        send_cmd(28'h3000, 16'd6);
        wait_done(d0);
        rdy_mode = 0;
        chk("t048_issued", iss_log.size() - base, 6);
        for (int k = 0; k < 6; k++) chk("t048_addr", iss_log[base + k], 28'h3000 + 28'(8 * k));

        // Zero-beat command
        base = iss_log.size(); d0 = n_done;
        send_cmd(28'h4000, 16'd0);
        @(negedge clk);
        chk("t049_done", done, 1);
        @(negedge clk);
        chk("t049_done_clear", done, 0);
        chk("t049_no_issue", iss_log.size() - base, 0);

        // Address wrap
        base = iss_log.size(); d0 = n_done;
        send_cmd(28'hFFFFFF8, 16'd2);
        wait_done(d0);
        chk("t051_addr0", iss_log[base], 28'hFFFFFF8);
        chk("t051_addr1", iss_log[base + 1], 28'h0000000);

        // Randomized transfers
        rdy_mode = 1; ord_mode = 2;
        for (int i = 0; i < 8; i++) begin
            lat = $urandom_range(1, 6);
            d0 = n_done;
            send_cmd(28'($urandom), 16'($urandom_range(1, 50)));
            wait_done(d0);
        end
        rdy_mode = 0; ord_mode = 0; lat = 8;

        // Reset mid-transfer, stray returns, then recovery
        base = iss_log.size();
        send_cmd(28'h5000, 16'd8);
        t = 0;
        while (iss_log.size() - base < 2 && t < 1000) begin @(negedge clk); t++; end
        chk("t050_two_issued", iss_log.size() - base, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("t050_rst_flags", {cmd_ready, app_en, out_valid, out_last, busy, done, err}, 0);
        chk("t050_rst_addr", app_addr, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        stray_req = stray_req + 2;
        repeat (5) @(negedge clk);
        chk("t050_err", err, 1);
        chk("t050_out_valid", out_valid, 0);
        ord_mode = 1; lat = 3;
        base = iss_log.size(); o0 = n_out; d0 = n_done;
        send_cmd(28'h0, 16'd1);
        wait_done(d0);
        chk("t050_issued", iss_log.size() - base, 1);
        chk("t050_beats", n_out - o0, 1);
        chk("t050_err_sticky", err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mig_read_streamer.md
MIG_READ_STREAMER -- requirements
Module: mig_read_streamer

Interface
REQ-001 Parameter ADDR_W, default 28: width of the MIG app_addr bus.
REQ-002 Parameter DATA_W, default 128: width of the MIG read data bus and the output stream.
REQ-003 Parameter ADDR_INC, default 8: app_addr increment per issued read beat.
REQ-004 Parameter FIFO_DEPTH, default 16, power of two >= 4: capacity of the read-data buffer in beats.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 init_calib_complete  in  1  MIG calibration done.
REQ-008 cmd_valid  in  1  transfer request valid.
REQ-009 cmd_ready  out  1  block can accept a request.
REQ-010 cmd_addr  in  ADDR_W  start address.
REQ-011 cmd_beats  in  16  number of DATA_W beats to read.
REQ-012 app_en  out  1  MIG command strobe.
REQ-013 app_cmd  out  3  MIG command; constant 3'b001 (read).
REQ-014 app_addr  out  ADDR_W  MIG command address.
REQ-015 app_rdy  in  1  MIG accepts command this cycle.
REQ-016 app_rd_data  in  DATA_W  MIG read data.
REQ-017 app_rd_data_valid  in  1  MIG read data valid; cannot be back-pressured.
REQ-018 out_valid / out_ready / out_data[DATA_W] / out_last  out/in/out/out  stream to the accelerator controller.
REQ-019 busy  out  1  transfer in progress.
REQ-020 done  out  1  one-cycle pulse at transfer completion.
REQ-021 err  out  1  sticky: read data arrived with zero outstanding reads.

Function
REQ-022 States are IDLE, ISSUE and DRAIN; the block is in IDLE out of reset.
REQ-023 In IDLE, cmd_ready = init_calib_complete; a command is accepted on cmd_valid && cmd_ready, latching the address and beat count.
REQ-024 An accepted command with cmd_beats == 0 stays in IDLE and pulses done on the following cycle, with no MIG traffic.
REQ-025 An accepted command with cmd_beats > 0 moves to ISSUE on the next cycle; cmd_ready = 0 outside IDLE.
REQ-026 Credit rule: a new read is issued only when outstanding + fifo_count < FIFO_DEPTH, so the FIFO never overflows.
REQ-027 In ISSUE, app_en asserts when beats remain to issue and a credit is available.
REQ-028 Once asserted, app_en and app_addr hold stable until app_rdy; the read is issued on app_en && app_rdy.
REQ-029 Issued beats use addresses cmd_addr + k*ADDR_INC for k = 0..N-1, wrapping modulo 2^ADDR_W.
REQ-030 After the last read is issued, the state moves to DRAIN and app_en deasserts the same cycle.
REQ-031 outstanding increments on an issue and decrements on app_rd_data_valid; a simultaneous issue and return leaves it unchanged.
REQ-032 Each app_rd_data_valid beat is written to the FIFO; out_valid is asserted no earlier than one cycle later (first-word latency 1).
REQ-033 The FIFO accepts a simultaneous write and read, and a simultaneous write and read while full, without data loss.
REQ-034 out_data and out_last remain stable while out_valid && !out_ready.
REQ-035 out_last = 1 only on beat N of the transfer.
REQ-036 Beats are delivered in issue order; MIG returns data in order.
REQ-037 A transfer completes when the out_last beat is accepted (out_valid && out_ready); done pulses the next cycle and the state returns to IDLE.
REQ-038 busy = (state != IDLE).
REQ-039 app_rd_data_valid while outstanding == 0: the data is dropped and err sets, until reset.
REQ-040 init_calib_complete deasserting during a transfer has no effect on it.

Reset
REQ-041 On rst_n low, all outputs are immediately 0: cmd_ready, app_en, app_addr, out_valid, out_data, out_last, busy, done and err.
REQ-042 Reset also clears the state to IDLE, the FIFO, the counters and outstanding.
REQ-043 app_cmd reads 3'b001 at all times, including during reset.
REQ-044 Reset mid-transfer abandons the transfer.
REQ-045 Reads returning after reset fall under REQ-039.

Verification
REQ-046 calib=1, cmd addr=0x100, beats=4, app_rdy=1, 3-cycle read latency, out_ready=1 -> app_addr 0x100, 0x108, 0x110, 0x118; 4 out beats with last on the 4th; one done pulse.
REQ-047 beats=40, out_ready=0 -> exactly 16 reads issued, then app_en stays 0. Release out_ready -> remaining 24 reads issued; data in order; err=0.
REQ-048 app_rdy toggled 1-0-0-1 during ISSUE -> app_addr held stable while app_en && !app_rdy; no beat skipped or duplicated.
REQ-049 cmd beats=0 -> done pulses one cycle after acceptance; app_en never asserts.
REQ-050 Reset asserted after 2 of 8 beats issued -> outputs 0 asynchronously. After release, 2 stray app_rd_data_valid -> err=1, out_valid=0. A new 1-beat cmd at 0x0 completes normally.
REQ-051 Addr 2^ADDR_W-8, beats=2 -> app_addr 0x0FFFFFF8 then 0x0000000.
